// File: rtl/count_stream_checker.sv
// count_stream_checker
//   Receive-side monitor for a free-running counter stream. Once armed it
//   syncs to the first valid sample, then checks that each subsequent valid
//   sample is the previous one plus 1 (mod 2^WIDTH). It also flags samples at
//   or above LIMIT, counts violations in a saturating counter, detects the
//   terminal value FINAL and runs a watchdog on stalls in the stream.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst_n          asynchronous active-low reset
//   enable         arm monitor; low returns the FSM to IDLE
//   bound_check_en qualifies bound checks
//   count_valid    count is a valid sample this cycle
//   count          sampled counter value (WIDTH bits, unsigned)
//   seq_err        1-cycle pulse: sequence violation
//   bound_err      1-cycle pulse: bound violation
//   assert_fail    sticky: any violation or watchdog expiry since arm
//   err_count      total violations, saturating
//   done           sticky: FINAL reached with a correct increment
//   timeout        sticky: watchdog expired
//   state          FSM state: IDLE=0 SYNC=1 TRACK=2 DONE=3
module count_stream_checker #(
  parameter int WIDTH   = 4,
  parameter int LIMIT   = 10,
  parameter int FINAL   = 15,
  parameter int TIMEOUT = 64,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             bound_check_en,
  input  logic             count_valid,
  input  logic [WIDTH-1:0] count,
  output logic             seq_err,
  output logic             bound_err,
  output logic             assert_fail,
  output logic [ERR_W-1:0] err_count,
  output logic             done,
  output logic             timeout,
  output logic [1:0]       state
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH-1:0] FINAL_V = WIDTH'(FINAL);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] acc,
                                               input logic [1:0]       inc);
    logic [ERR_W:0] sum;
    sum = {1'b0, acc} + {{(ERR_W-1){1'b0}}, inc};
    if (sum[ERR_W]) return '1;
    return sum[ERR_W-1:0];
  endfunction

  // LIMIT may exceed 2^WIDTH, so compare in 32 bits.
  function automatic logic over_limit(input logic [WIDTH-1:0] v);
    return 32'(v) >= 32'(LIMIT);
  endfunction

  state_t           state_p0, state_p1;
  logic [WIDTH-1:0] prev_p0, prev_p1;
  logic [WIDTH-1:0] expect_p0;
  logic [WD_W-1:0]  wdog_p0, wdog_p1;
  logic             seq_p0, seq_p1;
  logic             bnd_p0, bnd_p1;
  logic             af_p0, af_p1;
  logic [ERR_W-1:0] err_p0, err_p1;
  logic             done_p0, done_p1;
  logic             to_p0, to_p1;

  // Natural WIDTH-bit wrap makes 2^WIDTH-1 -> 0 a legal increment.
  assign expect_p0 = prev_p1 + WIDTH'(1);

  // Stage p0: next-state and check evaluation on the current sample
  always_comb begin
    state_p0 = state_p1;
    prev_p0  = prev_p1;
    wdog_p0  = wdog_p1;
    seq_p0   = 1'b0;
    bnd_p0   = 1'b0;
    af_p0    = af_p1;
    err_p0   = err_p1;
    done_p0  = done_p1;
    to_p0    = to_p1;
    case (state_p1)
      IDLE: begin
        if (enable) begin
          state_p0 = SYNC;
          af_p0    = 1'b0;
          err_p0   = '0;
          done_p0  = 1'b0;
          to_p0    = 1'b0;
          wdog_p0  = '0;
        end
      end
      SYNC, TRACK: begin
        if (!enable) begin
          state_p0 = IDLE;
        end else if (count_valid) begin
          wdog_p0 = '0;
          prev_p0 = count;
          bnd_p0  = bound_check_en && over_limit(count);
          if (state_p1 == SYNC) begin
            // First sample only establishes the reference, even if it is FINAL.
            state_p0 = TRACK;
          end else begin
            seq_p0 = (count != expect_p0);
            if (!seq_p0 && (count == FINAL_V)) begin
              state_p0 = DONE;
              done_p0  = 1'b1;
            end
          end
          err_p0 = sat_add(err_p1, {1'b0, seq_p0} + {1'b0, bnd_p0});
          af_p0  = af_p1 | seq_p0 | bnd_p0;
        end else if (wdog_p1 == WD_LAST) begin
          // This idle cycle is the TIMEOUT-th in a row.
          wdog_p0  = wdog_p1 + WD_W'(1);
          to_p0    = 1'b1;
          af_p0    = 1'b1;
          state_p0 = DONE;
        end else begin
          wdog_p0 = wdog_p1 + WD_W'(1);
        end
      end
      DONE: begin
        if (!enable) state_p0 = IDLE;
      end
      default: state_p0 = IDLE;
    endcase
  end

  // Stage p1: registered state and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1 <= IDLE;
      prev_p1  <= '0;
      wdog_p1  <= '0;
      seq_p1   <= 1'b0;
      bnd_p1   <= 1'b0;
      af_p1    <= 1'b0;
      err_p1   <= '0;
      done_p1  <= 1'b0;
      to_p1    <= 1'b0;
    end else begin
      state_p1 <= state_p0;
      prev_p1  <= prev_p0;
      wdog_p1  <= wdog_p0;
      seq_p1   <= seq_p0;
      bnd_p1   <= bnd_p0;
      af_p1    <= af_p0;
      err_p1   <= err_p0;
      done_p1  <= done_p0;
      to_p1    <= to_p0;
    end
  end

  assign seq_err     = seq_p1;
  assign bound_err   = bnd_p1;
  assign assert_fail = af_p1;
  assign err_count   = err_p1;
  assign done        = done_p1;
  assign timeout     = to_p1;
  assign state       = state_p1;

endmodule

// File: tb/tb_count_stream_checker.sv
// tb_count_stream_checker
//   Directed bench for count_stream_checker. Two instances share the stimulus:
//   dut uses LIMIT=10, dut16 uses LIMIT=16. Outputs are packed as
//   {seq_err, bound_err, assert_fail, err_count[7:0], done, timeout, state[1:0]}.
module tb_count_stream_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       bound_check_en = 1'b0;
  logic       count_valid = 1'b0;
  logic [3:0] count = 4'd0;

  logic       seq_err, bound_err, assert_fail, done, timeout;
  logic [7:0] err_count;
  logic [1:0] state;
  logic       seq_err16, bound_err16, assert_fail16, done16, timeout16;
  logic [7:0] err_count16;
  logic [1:0] state16;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  count_stream_checker dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bound_check_en(bound_check_en),
    .count_valid(count_valid), .count(count),
    .seq_err(seq_err), .bound_err(bound_err), .assert_fail(assert_fail),
    .err_count(err_count), .done(done), .timeout(timeout), .state(state)
  );

  count_stream_checker #(.LIMIT(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bound_check_en(bound_check_en),
    .count_valid(count_valid), .count(count),
    .seq_err(seq_err16), .bound_err(bound_err16), .assert_fail(assert_fail16),
    .err_count(err_count16), .done(done16), .timeout(timeout16), .state(state16)
  );

  typedef struct {
    logic        en;
    logic        bce;
    logic        vld;
    logic [3:0]  cnt;
    logic [14:0] exp;
  } vec_t;

  vec_t tbl [43];

  function automatic logic [14:0] pk(input logic s, input logic b, input logic af,
                                     input int err, input logic d, input logic t,
                                     input int st);
    logic [7:0] e8;
    logic [1:0] s2;
    e8 = 8'(err);
    s2 = 2'(st);
    return {s, b, af, e8, d, t, s2};
  endfunction

  function automatic vec_t mk(input logic en, input logic bce, input logic vld,
                              input int cnt, input logic s, input logic b,
                              input logic af, input int err, input logic d,
                              input logic t, input int st);
    vec_t v;
    v.en  = en;
    v.bce = bce;
    v.vld = vld;
    v.cnt = 4'(cnt);
    v.exp = pk(s, b, af, err, d, t, st);
    return v;
  endfunction

  function automatic logic [14:0] act_main();
    return {seq_err, bound_err, assert_fail, err_count, done, timeout, state};
  endfunction

  function automatic logic [14:0] act_16();
    return {seq_err16, bound_err16, assert_fail16, err_count16, done16, timeout16, state16};
  endfunction

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic en, input logic bce, input logic vld, input logic [3:0] c);
    enable         = en;
    bound_check_en = bce;
    count_valid    = vld;
    count          = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Segment A: LIMIT=10 run 0..15 with bound checks (dut16 sees a clean run)
    tbl[0] = mk(1,1,0,0,  0,0,0,0,0,0,1);
    tbl[1] = mk(1,1,1,0,  0,0,0,0,0,0,2);
    for (int c = 1; c <= 9; c++) tbl[1+c] = mk(1,1,1,c, 0,0,0,0,0,0,2);
    tbl[11] = mk(1,1,1,10, 0,1,1,1,0,0,2);
    tbl[12] = mk(1,1,1,11, 0,1,1,2,0,0,2);
    tbl[13] = mk(1,1,1,12, 0,1,1,3,0,0,2);
    tbl[14] = mk(1,1,1,13, 0,1,1,4,0,0,2);
    tbl[15] = mk(1,1,1,14, 0,1,1,5,0,0,2);
    tbl[16] = mk(1,1,1,15, 0,1,1,6,1,0,3);
    tbl[17] = mk(1,1,0,0,  0,0,1,6,1,0,3);
    tbl[18] = mk(0,1,1,3,  0,0,1,6,1,0,0);
    // Segment B: skip 3 -> 5
    tbl[19] = mk(1,0,0,0,  0,0,0,0,0,0,1);
    tbl[20] = mk(1,0,1,0,  0,0,0,0,0,0,2);
    tbl[21] = mk(1,0,1,1,  0,0,0,0,0,0,2);
    tbl[22] = mk(1,0,1,2,  0,0,0,0,0,0,2);
    tbl[23] = mk(1,0,1,3,  0,0,0,0,0,0,2);
    tbl[24] = mk(1,0,1,5,  1,0,1,1,0,0,2);
    tbl[25] = mk(1,0,1,6,  0,0,1,1,0,0,2);
    tbl[26] = mk(0,0,0,0,  0,0,1,1,0,0,0);
    // Segment C: sync on 14, DONE ignores samples, re-arm, wrap, double errors
    tbl[27] = mk(1,0,0,0,  0,0,0,0,0,0,1);
    tbl[28] = mk(1,0,1,14, 0,0,0,0,0,0,2);
    tbl[29] = mk(1,0,1,15, 0,0,0,0,1,0,3);
    tbl[30] = mk(1,1,1,3,  0,0,0,0,1,0,3);
    tbl[31] = mk(0,0,0,0,  0,0,0,0,1,0,0);
    tbl[32] = mk(1,0,0,0,  0,0,0,0,0,0,1);
    tbl[33] = mk(1,1,1,15, 0,1,1,1,0,0,2);
    tbl[34] = mk(1,1,1,0,  0,0,1,1,0,0,2);
    tbl[35] = mk(1,1,1,1,  0,0,1,1,0,0,2);
    tbl[36] = mk(1,1,1,12, 1,1,1,3,0,0,2);
    tbl[37] = mk(1,0,1,13, 0,0,1,3,0,0,2);
    tbl[38] = mk(1,1,1,9,  1,0,1,4,0,0,2);
    tbl[39] = mk(1,1,0,0,  0,0,1,4,0,0,2);
    tbl[40] = mk(1,0,1,15, 1,0,1,5,0,0,2);
    tbl[41] = mk(1,0,1,0,  0,0,1,5,0,0,2);
    tbl[42] = mk(0,0,0,0,  0,0,1,5,0,0,0);

    // T1: reset held with random inputs
    for (int k = 0; k < 3; k++) begin
      enable         = 1'($urandom);
      bound_check_en = 1'($urandom);
      count_valid    = 1'($urandom);
      count          = 4'($urandom);
      @(posedge clk);
      #1;
      check($sformatf("reset_cyc%0d", k), act_main(), 15'd0);
    end
    enable = 1'b0; bound_check_en = 1'b0; count_valid = 1'b0; count = 4'd0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T2..T5 table
    for (int i = 0; i < 43; i++) begin
      step(tbl[i].en, tbl[i].bce, tbl[i].vld, tbl[i].cnt);
      check($sformatf("vec%0d", i), act_main(), tbl[i].exp);
      if (i == 17) check("limit16_clean_run", act_16(), pk(0,0,0,0,1,0,3));
    end

    // T6: stall watchdog
    step(1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b0, 1'b1, 4'd0);
    step(1'b1, 1'b0, 1'b1, 4'd1);
    for (int k = 0; k < 40; k++) step(1'b1, 1'b0, 1'b0, 4'd0);
    check("stall40", act_main(), pk(0,0,0,0,0,0,2));
    step(1'b1, 1'b0, 1'b1, 4'd2);
    for (int k = 0; k < 63; k++) step(1'b1, 1'b0, 1'b0, 4'd0);
    check("stall63", act_main(), pk(0,0,0,0,0,0,2));
    step(1'b1, 1'b0, 1'b0, 4'd0);
    check("stall64", act_main(), pk(0,0,1,0,0,1,3));
    check("stall64_l16", act_16(), pk(0,0,1,0,0,1,3));
    step(1'b1, 1'b0, 1'b1, 4'd3);
    check("timeout_hold", act_main(), pk(0,0,1,0,0,1,3));

    // Mid-run asynchronous reset clears before the next edge
    rst_n = 1'b0;
    #1;
    check("async_reset", act_main(), 15'd0);
    #2;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 4'd0);
    check("post_reset_idle", act_main(), 15'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
